imem_port_arbiter: RTL and testbench
====================================

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 64, memory depth in words.
REQ-003 Parameter STARVE_LIMIT, default 4, maximum consecutive loader grants while fetch waits.
REQ-004 Clocking SHALL be one clock, clk; reset SHALL be asynchronous, active-low, rst_n.
REQ-005 The ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- f_req  in  1  fetch read request
- f_addr  in  XLEN  fetch byte address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  XLEN  fetch read data
- l_req  in  1  loader request
- l_we  in  1  loader write (1) or read (0)
- l_addr  in  XLEN  loader byte address
- l_wdata  in  XLEN  loader write data
- l_gnt  out  1  loader granted this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  XLEN  loader read data
- mem_idx  out  $clog2(DEPTH)  word index to memory array
- mem_we  out  1  memory write enable
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory combinational read data
- addr_err  out  1  pulse: granted access was out of range

Function
REQ-006 At most one of f_gnt and l_gnt SHALL be high in any cycle; grants SHALL be combinational from requests and state.
REQ-007 Word index SHALL be addr[XLEN-1:2]; bits [1:0] SHALL be ignored.
REQ-008 Loader SHALL have priority when both request, subject to REQ-021.
REQ-009 The granted requester SHALL drive mem_idx, and for loader writes also mem_we and mem_wdata; mem_we SHALL be 0 otherwise.
REQ-010 Read latency SHALL be one cycle: mem_rdata captured at the grant edge appears on f_rdata/l_rdata with f_rvalid/l_rvalid high for exactly the following cycle.
REQ-011 Loader writes SHALL produce no l_rvalid.
REQ-012 Out-of-range access (index >= DEPTH) SHALL suppress mem_we, return read data all-zero, and pulse addr_err in the same cycle as rvalid (writes: the cycle after the grant).
REQ-013 f_rdata/l_rdata SHALL hold their last value when the corresponding rvalid is low.
REQ-014 The owner FSM SHALL have states IDLE, FETCH, and LOAD, recording the last-cycle grant; the next state SHALL be FETCH on f_gnt, LOAD on l_gnt, else IDLE.
REQ-015 Back-to-back grants SHALL be allowed every cycle with full throughput.
REQ-016 Requests SHALL be non-sticky: a requester not granted SHALL hold req and addr stable until granted.

Reset
REQ-017 While rst_n is low, all outputs except the combinational mem_idx SHALL be 0, the FSM SHALL be IDLE, and the starvation counter SHALL be 0.
REQ-018 Reset asserted with a read in flight SHALL drop its rvalid; no rvalid SHALL follow deassertion.
REQ-019 In the first cycle after deassertion, grants SHALL follow REQ-008 normally.

Configuration
REQ-020 Macro IMEM_ARB_STARVE_GUARD_EN SHALL compile the starvation guard in; without it, loader priority is absolute and the counter does not exist.
REQ-021 With the macro defined:
- the counter SHALL increment on each l_gnt while f_req is high;
- the counter SHALL clear on f_gnt or when f_req is low;
- when the counter equals STARVE_LIMIT, fetch SHALL win the next contention cycle.

Structure
REQ-022 A shared package SHALL hold the owner-state enum (IDLE, FETCH, LOAD) and the default XLEN/DEPTH constants.
REQ-023 One sub-module, imem_starve_ctr, SHALL hold the guard counter and be instantiated only under the macro.

Verification
REQ-024 The bench SHALL cover these scenarios:
- f_req=1, f_addr=0x8, mem[2]=0xDEADBEEF -> f_gnt the same cycle; f_rvalid=1, f_rdata=0xDEADBEEF the next cycle.
- Both request, l_we=1, l_addr=0x4, l_wdata=0x12345678 -> l_gnt=1, f_gnt=0, mem_we=1, mem_idx=1; a fetch of 0x4 two cycles later returns 0x12345678.
- l_req=1, l_addr=0x100 (index 64, DEPTH=64), read -> l_rvalid=1, l_rdata=0, addr_err=1 the next cycle; no memory write.
- Guard on, STARVE_LIMIT=4, both requesting continuously -> grant pattern L,L,L,L,F repeating; guard off -> L only.
- Reset asserted in the cycle after an f_gnt -> f_rvalid stays 0; all outputs 0 during reset.
- f_addr=0xB (misaligned) -> mem_idx=2; returns mem[2].

Source files
------------

// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and default sizing for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_DEPTH = 64;

   // Owner of the memory port during the previous cycle
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2
   } owner_e;

endpackage

// File: rtl/imem_port_arbiter_starve_ctr.sv
// imem_starve_ctr: counts consecutive loader wins while fetch waits.
// Exists only when IMEM_ARB_STARVE_GUARD_EN is defined.
`ifdef IMEM_ARB_STARVE_GUARD_EN
module imem_starve_ctr
   import imem_port_arbiter_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic f_req_i,
   input  logic f_gnt_i,
   input  logic l_gnt_i,
   output logic hit_o
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (f_gnt_i || !f_req_i) begin
         cnt_d = '0;
      end else if (l_gnt_i && (cnt_q != CW'(LIMIT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q == CW'(LIMIT));

endmodule
`endif

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one combinational-read memory port between fetch and loader.
// Define IMEM_ARB_STARVE_GUARD_EN to bound consecutive loader wins while fetch waits.
module imem_port_arbiter
   import imem_port_arbiter_pkg::*;
#(
   parameter int XLEN         = DEF_XLEN,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     f_req,
   input  logic [XLEN-1:0]          f_addr,
   output logic                     f_gnt,
   output logic                     f_rvalid,
   output logic [XLEN-1:0]          f_rdata,
   input  logic                     l_req,
   input  logic                     l_we,
   input  logic [XLEN-1:0]          l_addr,
   input  logic [XLEN-1:0]          l_wdata,
   output logic                     l_gnt,
   output logic                     l_rvalid,
   output logic [XLEN-1:0]          l_rdata,
   output logic [$clog2(DEPTH)-1:0] mem_idx,
   output logic                     mem_we,
   output logic [XLEN-1:0]          mem_wdata,
   input  logic [XLEN-1:0]          mem_rdata,
   output logic                     addr_err
);

   localparam int              IDX_W   = $clog2(DEPTH);
   localparam logic [XLEN-3:0] DEPTH_W = (XLEN-2)'(DEPTH);

   owner_e          owner_q, owner_d;
   logic            starve_hit;
   logic            oor;
   logic [XLEN-1:0] sel_addr;
   logic [XLEN-3:0] sel_word;
   logic [XLEN-1:0] rd_word;
   logic [XLEN-1:0] f_rdata_q, l_rdata_q;
   logic            l_wr_q, err_q;
   logic            unused_addr_lsbs;

`ifdef IMEM_ARB_STARVE_GUARD_EN
   imem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .f_req_i (f_req),
      .f_gnt_i (f_gnt),
      .l_gnt_i (l_gnt),
      .hit_o   (starve_hit)
   );
`else
   assign starve_hit = 1'b0;
`endif

   // Grants are forced low during reset so every output except mem_idx reads 0
   assign l_gnt = rst_n & l_req & ~(f_req & starve_hit);
   assign f_gnt = rst_n & f_req & ~l_gnt;

   assign sel_addr  = l_gnt ? l_addr : f_addr;
   assign sel_word  = sel_addr[XLEN-1:2];
   assign oor       = (sel_word >= DEPTH_W);
   assign mem_idx   = sel_word[IDX_W-1:0];
   assign mem_we    = l_gnt & l_we & ~oor;
   assign mem_wdata = mem_we ? l_wdata : '0;
   assign rd_word   = oor ? '0 : mem_rdata;

   assign unused_addr_lsbs = ^{f_addr[1:0], l_addr[1:0]};

   always_comb begin
      owner_d = IDLE;
      if (f_gnt) begin
         owner_d = FETCH;
      end else if (l_gnt) begin
         owner_d = LOAD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= IDLE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Read data is held between valid pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_wr_q    <= 1'b0;
         err_q     <= 1'b0;
         f_rdata_q <= '0;
         l_rdata_q <= '0;
      end else begin
         l_wr_q <= l_we;
         err_q  <= (f_gnt | l_gnt) & oor;
         if (f_gnt) begin
            f_rdata_q <= rd_word;
         end
         if (l_gnt && !l_we) begin
            l_rdata_q <= rd_word;
         end
      end
   end

   assign f_rvalid = (owner_q == FETCH);
   assign l_rvalid = (owner_q == LOAD) & ~l_wr_q;
   assign f_rdata  = f_rdata_q;
   assign l_rdata  = l_rdata_q;
   assign addr_err = err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_imem_port_arbiter;

   localparam int XLEN  = 32;
   localparam int DEPTH = 64;
   localparam int LIMIT = 4;
`ifdef IMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            f_req, l_req, l_we;
   logic [31:0]     f_addr, l_addr, l_wdata;
   logic            f_gnt, f_rvalid, l_gnt, l_rvalid, mem_we, addr_err;
   logic [31:0]     f_rdata, l_rdata, mem_wdata, mem_rdata;
   logic [5:0]      mem_idx;

   logic [31:0]     mem     [0:DEPTH-1];
   logic [31:0]     ref_mem [0:DEPTH-1];

   int              n_cmp = 0;
   int              n_bad = 0;

   bit              exp_frv, exp_lrv, exp_err;
   logic [31:0]     exp_frd, exp_lrd;
   int              cnt;
   bit              m_fg, m_lg;

   imem_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .mem_idx(mem_idx), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_idx];
   always @(posedge clk) if (mem_we) mem[mem_idx] <= mem_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: evaluated once per cycle at the falling edge
   always @(negedge clk) begin : cmp
      bit          eg_l, eg_f, oorm;
      logic [31:0] a;
      int unsigned w;
      if (!rst_n) begin
         chk("rst_f_gnt", f_gnt, 0);       chk("rst_l_gnt", l_gnt, 0);
         chk("rst_f_rvalid", f_rvalid, 0); chk("rst_l_rvalid", l_rvalid, 0);
         chk("rst_f_rdata", f_rdata, 0);   chk("rst_l_rdata", l_rdata, 0);
         chk("rst_mem_we", mem_we, 0);     chk("rst_mem_wdata", mem_wdata, 0);
         chk("rst_addr_err", addr_err, 0);
         exp_frv = 0; exp_lrv = 0; exp_err = 0; exp_frd = 0; exp_lrd = 0;
         cnt = 0; m_fg = 0; m_lg = 0;
      end else begin
         chk("f_rvalid", f_rvalid, exp_frv); chk("f_rdata", f_rdata, exp_frd);
         chk("l_rvalid", l_rvalid, exp_lrv); chk("l_rdata", l_rdata, exp_lrd);
         chk("addr_err", addr_err, exp_err);

         eg_l = l_req && !(GUARD && f_req && cnt == LIMIT);
         eg_f = f_req && !eg_l;
         a    = eg_l ? l_addr : f_addr;
         w    = a >> 2;
         oorm = (w >= DEPTH);

         chk("f_gnt", f_gnt, eg_f);
         chk("l_gnt", l_gnt, eg_l);
         chk("mem_we", mem_we, eg_l && l_we && !oorm);
         if (eg_f || eg_l) chk("mem_idx", mem_idx, w % DEPTH);
         if (eg_l && l_we && !oorm) chk("mem_wdata", mem_wdata, l_wdata);

         exp_err = (eg_f || eg_l) && oorm;
         exp_frv = eg_f;
         if (eg_f) exp_frd = oorm ? 32'h0 : ref_mem[w];
         exp_lrv = eg_l && !l_we;
         if (eg_l && !l_we) exp_lrd = oorm ? 32'h0 : ref_mem[w];
         if (eg_l && l_we && !oorm) ref_mem[w] = l_wdata;
         if (eg_f || !f_req) cnt = 0;
         else if (eg_l) cnt++;
         m_fg = eg_f; m_lg = eg_l;
      end
   end

   task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                        input logic [31:0] la, input logic [31:0] lwd);
      f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_addr();
      case ($urandom_range(0, 9))
         0:       return $urandom;
         1:       return 32'($urandom_range(256, 300));
         default: return 32'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = (i * 32'h01010101) ^ 32'hA5A50000;
         ref_mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
      end
      mem[2] = 32'hDEADBEEF; ref_mem[2] = 32'hDEADBEEF;
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      nxt();

      // Plain fetch read
      drive(1, 32'h8, 0, 0, 0, 0);
      #5 chk("s1_f_gnt", f_gnt, 1);
      nxt(); drive(0, 0, 0, 0, 0, 0);
      #5 chk("s1_f_rvalid", f_rvalid, 1); chk("s1_f_rdata", f_rdata, 32'hDEADBEEF);
      nxt();

      // Contended loader write, then read back through fetch
      drive(1, 32'h20, 1, 1, 32'h4, 32'h12345678);
      #5 chk("s2_l_gnt", l_gnt, 1); chk("s2_f_gnt", f_gnt, 0);
      chk("s2_mem_we", mem_we, 1); chk("s2_mem_idx", mem_idx, 1);
      nxt(); drive(1, 32'h20, 0, 0, 0, 0);
      nxt(); drive(1, 32'h4, 0, 0, 0, 0);
      #5 chk("s2_rd_gnt", f_gnt, 1);
      nxt(); drive(0, 0, 0, 0, 0, 0);
      #5 chk("s2_rdback", f_rdata, 32'h12345678);
      nxt();

      // Out-of-range loader read and write
      drive(0, 0, 1, 0, 32'h100, 0);
      #5 chk("s3_mem_we", mem_we, 0);
      nxt(); drive(0, 0, 0, 0, 0, 0);
      #5 chk("s3_l_rvalid", l_rvalid, 1); chk("s3_l_rdata", l_rdata, 0); chk("s3_err", addr_err, 1);
      nxt(); drive(0, 0, 1, 1, 32'h104, 32'h55);
      #5 chk("s3w_mem_we", mem_we, 0);
      nxt(); drive(0, 0, 0, 0, 0, 0);
      #5 chk("s3w_err", addr_err, 1); chk("s3w_l_rvalid", l_rvalid, 0);
      nxt();

      // Misaligned fetch address
      drive(1, 32'hB, 0, 0, 0, 0);
      #5 chk("s6_mem_idx", mem_idx, 2);
      nxt(); drive(0, 0, 0, 0, 0, 0);
      #5 chk("s6_f_rdata", f_rdata, 32'hDEADBEEF);
      nxt();

      // Continuous contention: L,L,L,L,F with the guard, L only without
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h10, 1, 0, 32'(i * 4), 0);
         #5 chk("s4_l_gnt", l_gnt, (GUARD && (i % 5) == 4) ? 0 : 1);
         nxt();
      end
      drive(0, 0, 0, 0, 0, 0);
      nxt();

      // Reset right after a fetch grant drops the pending rvalid
      drive(1, 32'h8, 0, 0, 0, 0);
      nxt();
      rst_n = 1'b0;
      drive(1, 32'h8, 1, 0, 32'h4, 0);
      #5 chk("s5_f_rvalid", f_rvalid, 0); chk("s5_f_gnt", f_gnt, 0); chk("s5_l_gnt", l_gnt, 0);
      nxt(); nxt();
      rst_n = 1'b1;
      #5 chk("s5_post_l_gnt", l_gnt, 1); chk("s5_post_f_rvalid", f_rvalid, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0);
      nxt();

      // Randomized traffic; an ungranted requester holds its request
      for (int i = 0; i < 500; i++) begin
         if (!(f_req && !m_fg)) begin
            f_req  = ($urandom_range(0, 2) != 0);
            f_addr = rnd_addr();
         end
         if (!(l_req && !m_lg)) begin
            l_req   = ($urandom_range(0, 2) != 0);
            l_we    = $urandom_range(0, 1);
            l_addr  = rnd_addr();
            l_wdata = $urandom;
         end
         nxt();
      end
      drive(0, 0, 0, 0, 0, 0);
      nxt(); nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
